// File: rtl/unpacked_history_pkg.sv
// Width helpers shared by the history buffer and its bench.
// Kept free of M/DEPTH-dependent typedefs so every instance can size its own types.
package unpacked_history_pkg;

  function automatic int unsigned sel_width(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned fill_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/history_stage.sv
// One history entry: sample data plus a valid flag, loaded from the previous entry on shift.
module history_stage #(
  parameter int unsigned M = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         shift,
  input  logic         clear,
  input  logic [M-1:0] d_in,
  input  logic         v_in,
  output logic [M-1:0] q,
  output logic         q_valid
);

  logic [M-1:0] r_data;
  logic         r_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (clear) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (shift) begin
      r_data  <= d_in;
      r_valid <= v_in;
    end
  end

  assign q       = r_data;
  assign q_valid = r_valid;

endmodule

// File: rtl/unpacked_history_buf.sv
// Keeps the last DEPTH accepted samples (q[0] newest) with a fill count, sticky drop flag
// and a registered random-access tap read.
module unpacked_history_buf
  import unpacked_history_pkg::*;
#(
  parameter int unsigned  M     = 2,
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned SELW  = sel_width(DEPTH),
  localparam int unsigned FW    = fill_width(DEPTH)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            in_valid,
  input  logic [M-1:0]    d,
  input  logic            freeze,
  output logic [M-1:0]    q       [0:DEPTH-1],
  output logic            q_valid [0:DEPTH-1],
  output logic [FW-1:0]   fill,
  output logic            full,
  output logic            dropped,
  input  logic            rd_en,
  input  logic [SELW-1:0] rd_sel,
  output logic [M-1:0]    rd_data,
  output logic            rd_valid,
  output logic            rd_err
);

  logic          w_shift;
  logic [FW-1:0] r_fill;
  logic          r_dropped;
  logic [M-1:0]  r_rd_data;
  logic          r_rd_valid;
  logic          r_rd_err;
  logic [M-1:0]  w_tap_data;
  logic          w_tap_valid;
  logic          w_sel_ok;

  assign w_shift = in_valid & ~freeze & ~clear;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      history_stage #(.M(M)) u_stage (
        .clock   (clock),
        .reset_n (reset_n),
        .shift   (w_shift),
        .clear   (clear),
        .d_in    (d),
        .v_in    (1'b1),
        .q       (q[i]),
        .q_valid (q_valid[i])
      );
    end else begin : g_tail
      history_stage #(.M(M)) u_stage (
        .clock   (clock),
        .reset_n (reset_n),
        .shift   (w_shift),
        .clear   (clear),
        .d_in    (q[i-1]),
        .v_in    (q_valid[i-1]),
        .q       (q[i]),
        .q_valid (q_valid[i])
      );
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fill    <= '0;
      r_dropped <= 1'b0;
    end else if (clear) begin
      r_fill    <= '0;
      r_dropped <= 1'b0;
    end else begin
      if (w_shift && (r_fill != FW'(DEPTH))) begin
        r_fill <= r_fill + 1'b1;
      end
      if (freeze && in_valid) begin
        r_dropped <= 1'b1;
      end
    end
  end

  // Decode by comparison so out-of-range selects on non-power-of-2 depths never index q.
  always_comb begin
    w_tap_data  = '0;
    w_tap_valid = 1'b0;
    w_sel_ok    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_sel == SELW'(i)) begin
        w_sel_ok    = 1'b1;
        w_tap_data  = q[i];
        w_tap_valid = q_valid[i];
      end
    end
  end

  // The read port ignores clear so a read in the flush cycle still returns pre-edge history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else if (rd_en) begin
      r_rd_data  <= w_tap_data;
      r_rd_valid <= w_tap_valid;
      r_rd_err   <= ~w_sel_ok;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end
  end

  assign fill     = r_fill;
  assign full     = (r_fill == FW'(DEPTH));
  assign dropped  = r_dropped;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign rd_err   = r_rd_err;

endmodule

// File: doc/unpacked_history_buf.md
# unpacked_history_buf

Parametrised history buffer for M-bit samples. It keeps the last DEPTH accepted samples and exposes them as an unpacked-array output port declared with ascending ranges, plus a registered random-access tap read. It supersedes the fixed single-stage unpacked-port block. It sits behind sampled status buses and is used as a TMRG test vehicle for unpacked arrays of packed vectors on ports.

## Interface
Parameters:
- M, 2, sample width in bits (≥1)
- DEPTH, 4, number of history entries (≥2)
- SELW, $clog2(DEPTH), tap-select width; localparam, not overridable

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous flush of all state
- in_valid  input  1  sample strobe
- d  input  M  sample data
- freeze  input  1  hold history; incoming samples are dropped
- q  output  logic [M-1:0] q [0:DEPTH-1]  history; q[0] is the newest sample
- q_valid  output  logic q_valid [0:DEPTH-1]  entry holds a real sample
- fill  output  $clog2(DEPTH+1)  number of valid entries
- full  output  1  fill == DEPTH
- dropped  output  1  sticky; a sample arrived while frozen
- rd_en  input  1  tap read request
- rd_sel  input  SELW  tap index
- rd_data  output  M  registered tap data
- rd_valid  output  1  registered; the selected entry was valid
- rd_err  output  1  registered; rd_sel ≥ DEPTH

## Operation
- Reset: all q = 0, q_valid = 0, fill = 0, full = 0, dropped = 0, rd_data = 0, rd_valid = 0, rd_err = 0.
- Priority per edge: clear > freeze > in_valid.
- clear: same outputs as reset, except the read port. The read port still services an rd_en presented in the same cycle.
- Shift, when in_valid=1, freeze=0 and clear=0:
  - q[0] ← d, q[i] ← q[i-1]; q_valid shifts the same way with q_valid[0] ← 1.
  - q[DEPTH-1] is discarded.
  - fill ← min(fill+1, DEPTH).
- freeze=1 and in_valid=1: history unchanged; dropped ← 1.
- freeze=1 and in_valid=0: everything holds.
- dropped is cleared only by clear or reset.
- Tap read, when rd_en=1:
  - rd_sel < DEPTH: rd_data ← q[rd_sel], rd_valid ← q_valid[rd_sel], rd_err ← 0.
  - rd_sel ≥ DEPTH (only possible for non-power-of-2 DEPTH): rd_data ← 0, rd_valid ← 0, rd_err ← 1.
- rd_en=0: rd_valid and rd_err ← 0; rd_data holds.
- Width rules:
  - fill never wraps; it saturates at DEPTH.
  - SELW is computed so DEPTH=2 gives a 1-bit selector.

## Timing
- Shift latency 1: d sampled at edge k appears on q[0] after edge k.
- Read latency 1. The read samples pre-edge history, so a read and a shift at the same edge return the old q[rd_sel].
- full and fill update on the same edge as the shift that changes them.
- reset_n assertion mid-shift or mid-read clears all outputs immediately (asynchronously). Deassertion is expected to be synchronised upstream.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package unpacked_history_pkg:
  - function sel_width(depth), returning max(1, $clog2(depth))
  - function fill_width(depth)
  - no typedefs depending on M or DEPTH; those stay module-local.
- Sub-module history_stage(M): one entry holding data and valid.
  - Inputs: shift, clear, d_in, v_in.
  - Instantiated DEPTH times via generate, chained q[i-1] → q[i].
- Top level holds the fill counter, dropped flag and read register.

## Test plan
- Reset, then 3 samples 2'b01, 2'b10, 2'b11 → q = {3,2,1,0}, q_valid = {1,1,1,0}, fill = 3, full = 0.
- 6 consecutive samples 0,1,2,3,0,1 → q = {1,0,3,2}, fill saturates at 4, full = 1 from the 4th sample on.
- freeze=1 with in_valid=1 for 2 cycles → q unchanged, dropped = 1 and stays 1 after freeze=0; clear → dropped = 0, fill = 0, all q_valid = 0.
- History full of {3,2,1,0}; rd_en=1, rd_sel=2 with a simultaneous shift of d=1 → next cycle rd_data = 1 (old q[2]), rd_valid = 1, and q = {1,3,2,1}.
- DEPTH=3: rd_sel=3 → rd_err = 1, rd_valid = 0, rd_data = 0 for one cycle; rd_sel=2 on an empty buffer → rd_valid = 0, rd_err = 0.
- reset_n pulsed low mid-stream, between edges → all outputs read 0 before the next clock edge; clear and in_valid asserted together → clear wins, fill = 0.
